jt49_lerp: RTL and testbench

- Linear-interpolating upsampler for PSG audio paths.
- Accepts signed samples at a slow input strobe and emits a straight-line ramp at an output strobe that is 2^ratio times faster.
- Sits downstream of the moving averager and channel mixer, in front of faster-rate filters or DAC modulators.
- It performs the reverse job of the averager: that block smooths and decimates, this one rebuilds intermediate points.

---
 rtl/jt49_lerp.sv | 129 ++++++++++++
 tb/tb_jt49_lerp.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/jt49_lerp.sv
// ---------------------------------------------------------------------------
// jt49_lerp - linear-interpolating upsampler for PSG audio paths.
//
// Each cen_in strobe accepts a new signed sample. The block then walks a
// straight line from the previous sample to the new one in 2^ratio equal
// steps, one step per cen_out strobe. It is the inverse of the moving
// averager: the averager smooths and decimates, and this block rebuilds the
// points in between.
//
// Parameters:
//   dw     sample width (signed) of din and dout
//   ratio  log2 of the upsample factor (>= 1)
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   cen_in   input-sample strobe; din is sampled while high
//   cen_out  output-step strobe; nominally 2^ratio pulses per cen_in period
//   din      signed input sample
//   dout     signed interpolated sample, registered
//   hold     high once the ramp has reached its target
//
// Build option:
//   JT49_LERP_ROUND_EN  when defined, dout rounds half up instead of
//                       truncating toward -inf.
// ---------------------------------------------------------------------------
module jt49_lerp #(
  parameter int dw    = 8,
  parameter int ratio = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen_in,
  input  logic                 cen_out,
  input  logic signed [dw-1:0] din,
  output logic signed [dw-1:0] dout,
  output logic                 hold
);

  // Accumulator width: integer part dw bits, ratio fractional bits.
  localparam int AW = dw + ratio;

  // Step count at which the ramp lands exactly on the new sample.
  localparam logic [ratio:0] CNT_FULL = (ratio+1)'(1) << ratio;
  localparam logic [ratio:0] CNT_ONE  = (ratio+1)'(1);

  logic signed [dw-1:0] prev_q, prev_d;
  logic signed [AW-1:0] acc_q,  acc_d;
  logic signed [dw:0]   step_q, step_d;
  logic [ratio:0]       cnt_q,  cnt_d;
  logic signed [dw-1:0] dout_q, dout_d;
  logic                 hold_q, hold_d;

  // Span to the new sample, one bit wider than the samples so that any
  // difference of two dw-bit values fits.
  logic signed [dw:0]   step_new;
  // Step widened to the accumulator width (sign-extended).
  logic signed [AW-1:0] step_ext;

  always_comb begin
    step_new = $signed({din[dw-1], din}) - $signed({prev_q[dw-1], prev_q});
    step_ext = AW'(step_q);
  end

  // Ramp state update. cen_in has priority over cen_out.
  always_comb begin
    prev_d = prev_q;
    acc_d  = acc_q;
    step_d = step_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;

    if (cen_in) begin
      // Restart from the previous target rather than the current acc, so
      // the arithmetic stays exact even if the last ramp was cut short.
      step_d = step_new;
      acc_d  = {prev_q, {ratio{1'b0}}};
      prev_d = din;
      cnt_d  = '0;
      hold_d = 1'b0;
    end else if (cen_out && (cnt_q < CNT_FULL)) begin
      // acc stays between the old and new samples, so it cannot overflow.
      acc_d = acc_q + step_ext;
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_d == CNT_FULL) begin
        hold_d = 1'b1;
      end
    end
  end

`ifdef JT49_LERP_ROUND_EN
  // Round half up: add one half LSB, one bit wider than acc. The rounded
  // value never exceeds the larger endpoint, so the top bit can be dropped.
  localparam logic [AW:0] RHALF = (AW+1)'(1) << (ratio-1);
  logic [AW:0] rsum;

  always_comb begin
    rsum   = {acc_q[AW-1], acc_q} + RHALF;
    dout_d = rsum[AW-1:ratio];
  end
`else
  // Truncation toward -inf: just drop the fractional bits.
  always_comb begin
    dout_d = acc_q[AW-1:ratio];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      acc_q  <= '0;
      step_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      hold_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
      acc_q  <= acc_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      hold_q <= hold_d;
    end
  end

  assign dout = dout_q;
  assign hold = hold_q;

endmodule

// File: tb/tb_jt49_lerp.sv
module tb_jt49_lerp;

  localparam int DW = 8;
  localparam int R  = 3;
  localparam int N  = 1 << R;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cen_in;
  logic                 cen_out;
  logic signed [DW-1:0] din;
  logic signed [DW-1:0] dout;
  logic                 hold;

  always #5 clk = ~clk;

  jt49_lerp #(.dw(DW), .ratio(R)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen_in  (cen_in),
    .cen_out (cen_out),
    .din     (din),
    .dout    (dout),
    .hold    (hold)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: the ramp is described by its endpoints and how many
  // steps have been taken; the accumulator value follows from the formula.
  int m_old  = 0;
  int m_new  = 0;
  int m_k    = 0;
  int m_dout = 0;
  int m_hold = 1;

  function automatic int m_acc();
    return m_old * N + m_k * (m_new - m_old);
  endfunction

  function automatic int m_out(input int a);
`ifdef JT49_LERP_ROUND_EN
    return (a + N / 2) >>> R;
`else
    return a >>> R;
`endif
  endfunction

  task automatic m_reset();
    m_old  = 0;
    m_new  = 0;
    m_k    = 0;
    m_dout = 0;
    m_hold = 1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock with the given inputs; model advances and outputs are compared.
  task automatic tick(input bit ci, input bit co, input int d);
    cen_in  = ci;
    cen_out = co;
    din     = DW'(d);
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      m_dout = m_out(m_acc());
      if (ci) begin
        m_old  = m_new;
        m_new  = int'(din);
        m_k    = 0;
        m_hold = 0;
      end else if (co && m_k < N) begin
        m_k++;
        if (m_k == N) m_hold = 1;
      end
    end
    #1;
    check("model_dout", int'(dout), m_dout);
    check("model_hold", int'(hold), m_hold);
  endtask

  typedef struct {
    bit ci;
    bit co;
    int d;
    int exp_t;
    int exp_r;
    bit exp_hold;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit ci, input bit co, input int d,
                              input int et, input int er, input bit h);
    vec_t v;
    v.ci = ci; v.co = co; v.d = d; v.exp_t = et; v.exp_r = er; v.exp_hold = h;
    vecs.push_back(v);
  endfunction

  // Strobe cycle followed by an idle cycle, then compare with a constant.
  task automatic event_check(input string name, input bit ci, input bit co,
                             input int d, input int exp_dout, input bit exp_hold);
    tick(ci, co, d);
    tick(1'b0, 1'b0, d);
    check({name, "_dout"}, int'(dout), exp_dout);
    check({name, "_hold"}, int'(hold), int'(exp_hold));
  endtask

  initial begin
    int t3[8] = '{0, 1, 1, 2, 3, 3, 4, 5};
    int r3[8] = '{1, 1, 2, 3, 3, 4, 4, 5};
    int t4[8] = '{71, 43, 14, -14, -43, -71, -100, -128};
    int r4[8] = '{72, 43, 15, -14, -42, -71, -99, -128};
    int exp_v;
    logic [7:0] rnd;

    // Exact ramp 0 -> 80 plus one extra step at the target.
    add(1, 0, 80, 0, 0, 0);
    for (int k = 1; k <= N; k++) add(0, 1, 80, 10 * k, 10 * k, k == N);
    add(0, 1, 80, 80, 80, 1);
    // Fractional ramp 0 -> 5.
    add(1, 0, 0, 80, 80, 0);
    add(1, 0, 5, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 5, t3[i], r3[i], i == 7);
    // Full negative span 100 -> -128.
    add(1, 0, 100, 5, 5, 0);
    add(1, 0, -128, 100, 100, 0);
    for (int i = 0; i < 8; i++) add(0, 1, -128, t4[i], r4[i], i == 7);
    // Early sample with cen_in/cen_out collision.
    add(1, 0, 0, -128, -128, 0);
    add(1, 0, 80, 0, 0, 0);
    for (int k = 1; k <= 3; k++) add(0, 1, 80, 10 * k, 10 * k, 0);
    add(1, 1, 0, 80, 80, 0);
    for (int k = 1; k <= N; k++) add(0, 1, 0, 80 - 10 * k, 80 - 10 * k, k == N);

    // Reset held with random activity on the inputs.
    rst_n   = 1'b0;
    cen_in  = 1'b0;
    cen_out = 1'b0;
    din     = '0;
    for (int i = 0; i < 6; i++) begin
      tick(1'($urandom), 1'($urandom), int'($urandom_range(0, 255)) - 128);
      check("rst_dout", int'(dout), 0);
      check("rst_hold", int'(hold), 1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      tick(1'b0, 1'b1, int'($urandom_range(0, 255)) - 128);
      check("idle_cout_dout", int'(dout), 0);
    end

    // Table-driven directed vectors.
    foreach (vecs[i]) begin
`ifdef JT49_LERP_ROUND_EN
      exp_v = vecs[i].exp_r;
`else
      exp_v = vecs[i].exp_t;
`endif
      event_check($sformatf("tbl%0d", i), vecs[i].ci, vecs[i].co, vecs[i].d,
                  exp_v, vecs[i].exp_hold);
    end

    // Asynchronous reset in the middle of a ramp 0 -> 80.
    event_check("ar_start", 1'b1, 1'b0, 80, 0, 1'b0);
    for (int k = 1; k <= 4; k++) event_check("ar_step", 1'b0, 1'b1, 80, 10 * k, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", int'(dout), 0);
    check("async_rst_hold", int'(hold), 1);
    m_reset();
    tick(1'b0, 1'b0, 0);
    rst_n = 1'b1;
    event_check("post_rst_start", 1'b1, 1'b0, 16, 0, 1'b0);
    for (int k = 1; k <= N; k++)
      event_check("post_rst_ramp", 1'b0, 1'b1, 16, 2 * k, k == N);

    // Randomized traffic against the model, including collisions and
    // early/late samples.
    for (int i = 0; i < 3000; i++) begin
      rnd = 8'($urandom);
      tick($urandom_range(0, 11) == 0, 1'($urandom), int'($signed(rnd)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
